// File: rtl/sap_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sap_pkg
// Description : Shared SAP definitions: program-loader state encoding, RAM
//               geometry constants and instruction opcodes used by benches.
// Revision    : 1.0  initial release
// ============================================================================
package sap_pkg;

  // Program RAM geometry: 16 words of 8 bits
  localparam int SAP_ADDR_W = 4;
  localparam int SAP_DATA_W = 8;

  // Program-loader session states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    DATA    = 3'd2,
    CSUM    = 3'd3,
    RELEASE = 3'd4,
    DONE    = 3'd5,
    ERR     = 3'd6
  } loader_state_t;

  // SAP instruction opcodes (upper nibble of a program byte)
  localparam logic [3:0] LDA = 4'h1;
  localparam logic [3:0] ADD = 4'h2;
  localparam logic [3:0] SUB = 4'h3;
  localparam logic [3:0] STA = 4'h4;
  localparam logic [3:0] LDI = 4'h5;
  localparam logic [3:0] JMP = 4'h6;
  localparam logic [3:0] JC  = 4'h7;
  localparam logic [3:0] JZ  = 4'h8;
  localparam logic [3:0] OUT = 4'hE;
  localparam logic [3:0] HLT = 4'hF;

endpackage
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Write side of the program-RAM path. Takes a length byte and
//               a stream of program bytes, writes them to the program RAM
//               while the CPU is held in programming mode, then releases the
//               CPU through a controlled reset so it starts fetching at 0.
// Revision    : 1.0  initial release
// Option      : PROG_LOADER_CSUM_EN - when defined, a trailing checksum byte
//               (8-bit sum of the data bytes) is required; a mismatch parks
//               the block in ERR with the CPU held in reset.
// Ports       :
//   clk        in   system clock (posedge)
//   rst        in   asynchronous reset, active low
//   start      in   1-cycle pulse, begins a load session
//   in_valid   in   stream byte valid
//   in_data    in   stream byte
//   in_ready   out  byte accepted when in_valid && in_ready
//   ram_we     out  RAM write strobe, one cycle per data byte
//   ram_addr   out  RAM write address
//   ram_wdata  out  RAM write data
//   prog_mode  out  CPU sequencer frozen while high
//   cpu_rst_n  out  active-low CPU reset
//   busy       out  session in progress
//   done       out  last session loaded cleanly, CPU running
//   err        out  last session failed its checksum
// ============================================================================
module prog_loader
  import sap_pkg::*;
#(
  parameter int ADDR_W      = SAP_ADDR_W,
  parameter int DATA_W      = SAP_DATA_W,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              prog_mode,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int                  c_HOLD_W    = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES);

  loader_state_t       r_state;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   r_last_idx;
  logic [c_HOLD_W-1:0] r_hold;

  logic                w_accept;
  logic [ADDR_W:0]     w_len_field;
  logic [ADDR_W-1:0]   w_last_idx;

  assign w_accept    = in_valid & in_ready;
  assign w_len_field = in_data[ADDR_W:0];
  // The session length is kept as the index of the final byte. A length
  // field of 0 or >= capacity selects the full RAM; 0 - 1 already wraps to
  // all ones, so only the overflow bit needs an explicit case. Storing the
  // last index keeps idx within ADDR_W bits and it never has to wrap.
  assign w_last_idx  = w_len_field[ADDR_W] ? '1 : (w_len_field[ADDR_W-1:0] - 1'b1);

`ifdef PROG_LOADER_CSUM_EN
  logic [DATA_W-1:0] r_acc;
  logic              r_err;
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      in_ready   <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      prog_mode  <= 1'b0;
      cpu_rst_n  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      r_idx      <= '0;
      r_last_idx <= '0;
      r_hold     <= '0;
`ifdef PROG_LOADER_CSUM_EN
      r_acc      <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      ram_we <= 1'b0;

      case (r_state)
        IDLE, DONE, ERR: begin
          if (start) begin
            r_state   <= LEN;
            in_ready  <= 1'b1;
            prog_mode <= 1'b1;
            cpu_rst_n <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            r_idx     <= '0;
`ifdef PROG_LOADER_CSUM_EN
            r_acc     <= '0;
            r_err     <= 1'b0;
`endif
          end else if (r_state == IDLE) begin
            // Leaving power-on reset: let the CPU run its (empty) program.
            cpu_rst_n <= 1'b1;
          end
        end

        LEN: begin
          if (w_accept) begin
            r_last_idx <= w_last_idx;
            r_state    <= DATA;
          end
        end

        DATA: begin
          if (w_accept) begin
            ram_we    <= 1'b1;
            ram_addr  <= r_idx;
            ram_wdata <= in_data;
`ifdef PROG_LOADER_CSUM_EN
            r_acc     <= r_acc + in_data;
`endif
            if (r_idx == r_last_idx) begin
`ifdef PROG_LOADER_CSUM_EN
              r_state  <= CSUM;
`else
              r_state  <= RELEASE;
              in_ready <= 1'b0;
              r_hold   <= '0;
`endif
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end

`ifdef PROG_LOADER_CSUM_EN
        CSUM: begin
          if (w_accept) begin
            in_ready <= 1'b0;
            if (in_data == r_acc) begin
              r_state <= RELEASE;
              r_hold  <= '0;
            end else begin
              // CPU stays frozen and in reset until the next start.
              r_state <= ERR;
              busy    <= 1'b0;
              r_err   <= 1'b1;
            end
          end
        end
`endif

        RELEASE: begin
          // prog_mode drops one cycle after entering RELEASE so the final
          // RAM write always completes while the sequencer is still frozen.
          prog_mode <= 1'b0;
          if (r_hold == c_HOLD_LAST) begin
            r_state   <= DONE;
            cpu_rst_n <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader. Sessions are built from
//               a length byte and data bytes; the expected RAM writes,
//               checksum outcome and release timing come from a queue-based
//               model of the load protocol.
// Revision    : 1.0  initial release
// ============================================================================
module tb_prog_loader;

  localparam int HOLD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       prog_mode;
  logic       cpu_rst_n;
  logic       busy;
  logic       done;
  logic       err;

  prog_loader #(
    .ADDR_W      (4),
    .DATA_W      (8),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .prog_mode (prog_mode),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every RAM write with its cycle stamp, plus release-window
  // and protocol-violation counters. Only this process writes these.
  int         cyc = 0;
  logic [3:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  int         wr_cyc_q[$];
  int         hold_cnt = 0;
  int         viol = 0;

  always @(negedge clk) begin
    cyc++;
    if (ram_we) begin
      wr_addr_q.push_back(ram_addr);
      wr_data_q.push_back(ram_wdata);
      wr_cyc_q.push_back(cyc);
      if (!prog_mode || cpu_rst_n) viol++;
    end
    if (busy && !prog_mode && !cpu_rst_n) hold_cnt++;
  end

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int t;
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("rdy_wait", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // mode 0: random data, 1: data = index, 2: 1E/2F/E0, 3: F0/20
  task automatic run_session(input logic [7:0] nfield, input int mode, input int gap_max,
                             input int glitch_after, input bit bad_csum, input bit b2b);
    logic [7:0] bytes[$];
    logic [7:0] t1[3];
    logic [7:0] t3[2];
    logic [7:0] sum;
    logic [7:0] b;
    int         n, base, hbase, vbase, t, rdy_seen, nwr;
    bit         ok;
    t1 = '{8'h1E, 8'h2F, 8'hE0};
    t3 = '{8'hF0, 8'h20};

    n = int'(nfield) % 32;
    if (n == 0 || n >= 16) n = 16;
    sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      case (mode)
        1:       b = 8'(i);
        2:       b = t1[i % 3];
        3:       b = t3[i % 2];
        default: b = 8'($urandom);
      endcase
      bytes.push_back(b);
      sum = sum + b;
    end

    base  = wr_addr_q.size();
    hbase = hold_cnt;
    vbase = viol;

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", {31'b0, busy}, 32'd1);
    check("start_pm",   {31'b0, prog_mode}, 32'd1);
    check("start_rstn", {31'b0, cpu_rst_n}, 32'd0);
    check("start_err",  {31'b0, err}, 32'd0);
    check("start_done", {31'b0, done}, 32'd0);
    check("start_rdy",  {31'b0, in_ready}, 32'd1);

    send_byte(nfield);
    for (int i = 0; i < n; i++) begin
      send_byte(bytes[i]);
      if (i + 1 == glitch_after) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end else if (gap_max > 0) begin
        repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      end
    end

`ifdef PROG_LOADER_CSUM_EN
    send_byte(bad_csum ? sum + 8'h01 : sum);
    ok = !bad_csum;
`else
    ok = 1'b1;
`endif

    // Offer a byte throughout the release; it must not be consumed.
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    rdy_seen = 0;
    t = 0;
    while (busy && t < 40) begin
      if (in_ready) rdy_seen++;
      @(negedge clk);
      t++;
    end
    check("finish_busy", {31'b0, busy}, 32'd0);
    check("rel_rdy", 32'(rdy_seen), 32'd0);
    check("end_rdy", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;

    nwr = wr_addr_q.size() - base;
    check("n_writes", 32'(nwr), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < wr_addr_q.size()) begin
        check("wr_addr", {28'b0, wr_addr_q[base + i]}, 32'(i));
        check("wr_data", {24'b0, wr_data_q[base + i]}, {24'b0, bytes[i]});
        if (b2b && i > 0)
          check("b2b", 32'(wr_cyc_q[base + i] - wr_cyc_q[base + i - 1]), 32'd1);
      end
    end
    check("viol", 32'(viol - vbase), 32'd0);
    check("hold", 32'(hold_cnt - hbase), ok ? 32'(HOLD) : 32'd0);
    check("done", {31'b0, done}, {31'b0, ok});
    check("err",  {31'b0, err},  {31'b0, !ok});
    check("pm",   {31'b0, prog_mode}, {31'b0, !ok});
    check("rstn", {31'b0, cpu_rst_n}, {31'b0, ok});

    if (!ok) begin
      repeat (5) @(negedge clk);
      check("err_hold",  {31'b0, err}, 32'd1);
      check("err_rstn",  {31'b0, cpu_rst_n}, 32'd0);
      check("err_pm",    {31'b0, prog_mode}, 32'd1);
    end
  endtask

  initial begin
    int base;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rdy",   {31'b0, in_ready}, 32'd0);
    check("rst_we",    {31'b0, ram_we}, 32'd0);
    check("rst_addr",  {28'b0, ram_addr}, 32'd0);
    check("rst_wdata", {24'b0, ram_wdata}, 32'd0);
    check("rst_pm",    {31'b0, prog_mode}, 32'd0);
    check("rst_rstn",  {31'b0, cpu_rst_n}, 32'd0);
    check("rst_busy",  {31'b0, busy}, 32'd0);
    check("rst_done",  {31'b0, done}, 32'd0);
    check("rst_err",   {31'b0, err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_rstn", {31'b0, cpu_rst_n}, 32'd1);

    // Byte offered in IDLE stays pending and becomes the next length field
    base = wr_addr_q.size();
    in_valid = 1'b1;
    in_data  = 8'h03;
    repeat (4) begin
      @(negedge clk);
      check("idle_rdy", {31'b0, in_ready}, 32'd0);
    end
    check("idle_nwr", 32'(wr_addr_q.size() - base), 32'd0);
    run_session(8'h03, 0, 0, -1, 1'b0, 1'b0);

    // Three bytes back-to-back
    run_session(8'h03, 2, 0, -1, 1'b0, 1'b1);
    // Length 0 means full RAM, gaps between bytes
    run_session(8'h00, 1, 3, -1, 1'b0, 1'b0);
    // Start during DATA is ignored
    run_session(8'h04, 0, 1, 1, 1'b0, 1'b0);
    // Length field above capacity also means full RAM
    run_session(8'h1B, 0, 0, -1, 1'b0, 1'b1);

`ifdef PROG_LOADER_CSUM_EN
    run_session(8'h02, 3, 0, -1, 1'b0, 1'b0);
    run_session(8'h02, 3, 0, -1, 1'b1, 1'b0);
`endif

    // Randomized sessions
    for (int s = 0; s < 6; s++) begin
`ifdef PROG_LOADER_CSUM_EN
      run_session(8'($urandom), 0, 2, -1, 1'($urandom_range(1, 0)), 1'b0);
`else
      run_session(8'($urandom), 0, 2, -1, 1'b0, 1'b0);
`endif
    end

    // Reset during DATA after 2 of 5 bytes
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h05);
    base = wr_addr_q.size();
    send_byte(8'hA5);
    send_byte(8'h5A);
    #1 rst = 1'b0;
    #1;
    check("mid_rdy",  {31'b0, in_ready}, 32'd0);
    check("mid_we",   {31'b0, ram_we}, 32'd0);
    check("mid_addr", {28'b0, ram_addr}, 32'd0);
    check("mid_pm",   {31'b0, prog_mode}, 32'd0);
    check("mid_rstn", {31'b0, cpu_rst_n}, 32'd0);
    check("mid_busy", {31'b0, busy}, 32'd0);
    check("mid_done", {31'b0, done}, 32'd0);
    repeat (3) @(negedge clk);
    check("mid_nwr", 32'(wr_addr_q.size() - base), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    check("mid_idle_rstn", {31'b0, cpu_rst_n}, 32'd1);

    // Normal session after the aborted one
    run_session(8'h05, 0, 1, -1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
